// File: rtl/rf_access_sequencer.sv
// Register-file access sequencer: accepts one decoded instruction, issues the
// regA/regB read, waits the read latency, presents operands, then writes back.
module rf_access_sequencer #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 8,
    parameter int RD_LAT   = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_ra,
    input  logic [ADDR_W-1:0] req_rb,
    input  logic [ADDR_W-1:0] req_rw,
    input  logic              req_wb,
    output logic [ADDR_W-1:0] regA,
    output logic [ADDR_W-1:0] regB,
    input  logic [DATA_W-1:0] dataA,
    input  logic [DATA_W-1:0] dataB,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] regW,
    output logic [DATA_W-1:0] dataW,
    output logic              RFwrite,
    output logic              done,
    output logic              err,
    output logic [1:0]        o_dbg_state
);

    // Handshakes: the request is taken on a rising edge where req_valid and
    // req_ready are both 1; the result is taken on an edge in EXEC where res_valid is 1.

    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [ADDR_W:0] NREG_EXT = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_EXEC    = 2'd2,
        S_WB      = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_rw;
    logic              r_wb;
    logic              r_src_err;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_rw_nxt;
    logic              w_wb_nxt;
    logic              w_src_err_nxt;
    logic [ADDR_W-1:0] w_rega_nxt;
    logic [ADDR_W-1:0] w_regb_nxt;
    logic              w_op_valid_nxt;
    logic [DATA_W-1:0] w_op_a_nxt;
    logic [DATA_W-1:0] w_op_b_nxt;
    logic [ADDR_W-1:0] w_regw_nxt;
    logic [DATA_W-1:0] w_dataw_nxt;
    logic              w_rfwrite_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_ready_nxt;

    function automatic logic illegal_reg(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= NREG_EXT;
    endfunction

    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rw_nxt       = r_rw;
        w_wb_nxt       = r_wb;
        w_src_err_nxt  = r_src_err;
        w_rega_nxt     = regA;
        w_regb_nxt     = regB;
        w_op_valid_nxt = op_valid;
        w_op_a_nxt     = op_a;
        w_op_b_nxt     = op_b;
        w_regw_nxt     = regW;
        w_dataw_nxt    = dataW;
        w_rfwrite_nxt  = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_ready_nxt    = req_ready;

        case (r_state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    w_rw_nxt      = req_rw;
                    w_wb_nxt      = req_wb;
                    // Illegal source registers are still read; the error surfaces at retire.
                    w_src_err_nxt = illegal_reg(req_ra) || illegal_reg(req_rb);
                    w_rega_nxt    = req_ra;
                    w_regb_nxt    = req_rb;
                    w_ready_nxt   = 1'b0;
                    w_cnt_nxt     = CNT_W'(RD_LAT);
                    w_state_nxt   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_op_a_nxt     = dataA;
                    w_op_b_nxt     = dataB;
                    w_op_valid_nxt = 1'b1;
                    w_state_nxt    = S_EXEC;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_EXEC: begin
                if (res_valid) begin
                    w_op_valid_nxt = 1'b0;
                    w_done_nxt     = 1'b1;
                    if (r_src_err || (r_wb && illegal_reg(r_rw))) begin
                        w_err_nxt   = 1'b1;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_wb) begin
                        w_regw_nxt    = r_rw;
                        w_dataw_nxt   = res_data;
                        w_rfwrite_nxt = 1'b1;
                        w_state_nxt   = S_WB;
                    end else begin
                        w_ready_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WB: begin
                w_ready_nxt = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_ready_nxt = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rw      <= '0;
            r_wb      <= 1'b0;
            r_src_err <= 1'b0;
            regA      <= '0;
            regB      <= '0;
            op_valid  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            regW      <= '0;
            dataW     <= '0;
            RFwrite   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rw      <= w_rw_nxt;
            r_wb      <= w_wb_nxt;
            r_src_err <= w_src_err_nxt;
            regA      <= w_rega_nxt;
            regB      <= w_regb_nxt;
            op_valid  <= w_op_valid_nxt;
            op_a      <= w_op_a_nxt;
            op_b      <= w_op_b_nxt;
            regW      <= w_regw_nxt;
            dataW     <= w_dataw_nxt;
            RFwrite   <= w_rfwrite_nxt;
            done      <= w_done_nxt;
            err       <= w_err_nxt;
            req_ready <= w_ready_nxt;
        end
    end

endmodule
